// File: rtl/nco_ctrl_pkg.sv
// Shared state encoding and default sizes for the NCO sweep controller.
package nco_ctrl_pkg;

  localparam int unsigned DEF_PHW        = 32;
  localparam int unsigned DEF_CW         = 16;
  localparam int unsigned DEF_RST_CYCLES = 2;
  localparam int unsigned DEF_VALID_TMO  = 64;

  typedef enum logic [2:0] {
    StIdle,
    StPrime,
    StWaitv,
    StDwell,
    StDone
  } state_e;

endpackage

// File: rtl/nco_ctrl_cnt.sv
// Up-counter with synchronous clear-to-zero and a terminal-count compare.
module nco_ctrl_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_hit
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_hit = (r_cnt == i_term);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped frequency sweep sequencer: primes the NCO, waits for out_valid, then dwells per point.
module nco_sweep_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int unsigned PHW        = DEF_PHW,
  parameter int unsigned CW         = DEF_CW,
  parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
  parameter int unsigned VALID_TMO  = DEF_VALID_TMO
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_abort,
  input  logic           i_cfg_loop,
  input  logic [PHW-1:0] i_cfg_start_inc,
  input  logic [PHW-1:0] i_cfg_step_inc,
  input  logic [CW-1:0]  i_cfg_num_pts,
  input  logic [CW-1:0]  i_cfg_dwell,
  input  logic           i_nco_out_valid,
  output logic [PHW-1:0] o_phi_inc,
  output logic           o_nco_clken,
  output logic           o_nco_reset_n,
  output logic           o_busy,
  output logic           o_step_strobe,
  output logic [CW-1:0]  o_pt_idx,
  output logic           o_done,
  output logic           o_err_tmo
);

  localparam logic [CW-1:0] PrimeLast = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TmoLast   = CW'(VALID_TMO - 1);

  state_e         r_state;
  logic [PHW-1:0] r_start_inc;
  logic [PHW-1:0] r_step_inc;
  logic [PHW-1:0] r_phi_inc;
  logic [CW-1:0]  r_num_last;
  logic [CW-1:0]  r_dwell_last;
  logic [CW-1:0]  r_pt_idx;
  logic           r_loop;
  logic           r_clken;
  logic           r_nco_rst_n;
  logic           r_busy;
  logic           r_strobe;
  logic           r_done;
  logic           r_err;

  logic [CW-1:0]  w_tc_term;
  logic           w_tc_clr;
  logic           w_tc_hit;
  logic           w_dc_clr;
  logic           w_dc_hit;
  logic           w_last_pt;

  // One counter times both the NCO reset pulse and the out_valid timeout.
  always_comb begin
    w_tc_term = (r_state == StPrime) ? PrimeLast : TmoLast;
    w_tc_clr  = ((r_state != StPrime) && (r_state != StWaitv)) ||
                ((r_state == StPrime) && w_tc_hit);
    w_dc_clr  = (r_state != StDwell) || w_dc_hit;
    w_last_pt = (r_pt_idx == r_num_last);
  end

  nco_ctrl_cnt #(
    .W(CW)
  ) u_tmo_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_tc_clr),
    .i_en   (1'b1),
    .i_term (w_tc_term),
    .o_hit  (w_tc_hit)
  );

  nco_ctrl_cnt #(
    .W(CW)
  ) u_dwell_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_dc_clr),
    .i_en   (1'b1),
    .i_term (r_dwell_last),
    .o_hit  (w_dc_hit)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_start_inc  <= '0;
      r_step_inc   <= '0;
      r_phi_inc    <= '0;
      r_num_last   <= '0;
      r_dwell_last <= '0;
      r_pt_idx     <= '0;
      r_loop       <= 1'b0;
      r_clken      <= 1'b0;
      r_nco_rst_n  <= 1'b0;
      r_busy       <= 1'b0;
      r_strobe     <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_nco_rst_n <= 1'b1;
          r_clken     <= 1'b0;
          r_busy      <= 1'b0;
          if (i_start) begin
            // Zero-valued count fields behave as one.
            r_start_inc  <= i_cfg_start_inc;
            r_step_inc   <= i_cfg_step_inc;
            r_num_last   <= (i_cfg_num_pts == '0) ? '0 : i_cfg_num_pts - CW'(1);
            r_dwell_last <= (i_cfg_dwell == '0) ? '0 : i_cfg_dwell - CW'(1);
            r_loop       <= i_cfg_loop;
            r_phi_inc    <= i_cfg_start_inc;
            r_pt_idx     <= '0;
            r_err        <= 1'b0;
            r_nco_rst_n  <= 1'b0;
            r_clken      <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= StPrime;
          end
        end
        StPrime: begin
          if (i_abort) begin
            r_nco_rst_n <= 1'b1;
            r_clken     <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= StDone;
          end else if (w_tc_hit) begin
            r_nco_rst_n <= 1'b1;
            r_state     <= StWaitv;
          end
        end
        StWaitv: begin
          if (i_abort) begin
            r_clken <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else if (i_nco_out_valid) begin
            r_state <= StDwell;
          end else if (w_tc_hit) begin
            r_err   <= 1'b1;
            r_clken <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDwell: begin
          if (i_abort) begin
            r_clken <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else if (w_dc_hit) begin
            if (!w_last_pt) begin
              r_phi_inc <= r_phi_inc + r_step_inc;
              r_pt_idx  <= r_pt_idx + CW'(1);
              r_strobe  <= 1'b1;
            end else if (r_loop) begin
              // Wrap without re-priming so the NCO phase stays continuous.
              r_phi_inc <= r_start_inc;
              r_pt_idx  <= '0;
              r_strobe  <= 1'b1;
            end else begin
              r_clken <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StDone;
            end
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_phi_inc     = r_phi_inc;
  assign o_nco_clken   = r_clken;
  assign o_nco_reset_n = r_nco_rst_n;
  assign o_busy        = r_busy;
  assign o_step_strobe = r_strobe;
  assign o_pt_idx      = r_pt_idx;
  assign o_done        = r_done;
  assign o_err_tmo     = r_err;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Randomized bench for nco_sweep_ctrl against a per-cycle expected trace built from sweep rules.
module tb_nco_sweep_ctrl;

  localparam int unsigned PHW        = 32;
  localparam int unsigned CW         = 16;
  localparam int unsigned RST_CYCLES = 2;
  localparam int unsigned VALID_TMO  = 64;
  localparam int unsigned VLAT       = 5;

  typedef struct packed {
    logic [PHW-1:0] phi;
    logic [CW-1:0]  pt;
    logic           strobe;
    logic           clken;
    logic           rstn;
    logic           busy;
    logic           done;
    logic           err;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           abort;
  logic           cfg_loop;
  logic [PHW-1:0] cfg_start_inc;
  logic [PHW-1:0] cfg_step_inc;
  logic [CW-1:0]  cfg_num_pts;
  logic [CW-1:0]  cfg_dwell;
  logic           nco_out_valid;
  logic [PHW-1:0] phi_inc;
  logic           nco_clken;
  logic           nco_reset_n;
  logic           busy;
  logic           step_strobe;
  logic [CW-1:0]  pt_idx;
  logic           done;
  logic           err_tmo;

  int n_checks = 0;
  int n_pass   = 0;

  logic stub_en;
  int   vcnt;

  always #5 clk = ~clk;

  nco_sweep_ctrl #(
    .PHW        (PHW),
    .CW         (CW),
    .RST_CYCLES (RST_CYCLES),
    .VALID_TMO  (VALID_TMO)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_abort         (abort),
    .i_cfg_loop      (cfg_loop),
    .i_cfg_start_inc (cfg_start_inc),
    .i_cfg_step_inc  (cfg_step_inc),
    .i_cfg_num_pts   (cfg_num_pts),
    .i_cfg_dwell     (cfg_dwell),
    .i_nco_out_valid (nco_out_valid),
    .o_phi_inc       (phi_inc),
    .o_nco_clken     (nco_clken),
    .o_nco_reset_n   (nco_reset_n),
    .o_busy          (busy),
    .o_step_strobe   (step_strobe),
    .o_pt_idx        (pt_idx),
    .o_done          (done),
    .o_err_tmo       (err_tmo)
  );

  // Stub NCO: out_valid rises VLAT clocked cycles after reset_n goes high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vcnt <= 0;
    else if (!nco_reset_n) vcnt <= 0;
    else if (nco_clken && vcnt < VLAT) vcnt <= vcnt + 1;
  end
  assign nco_out_valid = stub_en && (vcnt == VLAT);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".phi"}, phi_inc, 0);
    check({tag, ".clken"}, nco_clken, 0);
    check({tag, ".rstn"}, nco_reset_n, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".strobe"}, step_strobe, 0);
    check({tag, ".pt"}, pt_idx, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".err"}, err_tmo, 0);
  endtask

  task automatic cmp_cycle(input string tag, input int i, input exp_t e);
    string t;
    t = $sformatf("%s[%0d]", tag, i);
    check({t, ".phi"}, phi_inc, e.phi);
    check({t, ".pt"}, pt_idx, e.pt);
    check({t, ".strobe"}, step_strobe, e.strobe);
    check({t, ".clken"}, nco_clken, e.clken);
    check({t, ".rstn"}, nco_reset_n, e.rstn);
    check({t, ".busy"}, busy, e.busy);
    check({t, ".done"}, done, e.done);
    check({t, ".err"}, err_tmo, e.err);
  endtask

  // Builds the cycle-by-cycle expectation for one sweep, drives it and compares.
  task automatic run_sweep(input string tag, input logic [PHW-1:0] inc, input logic [PHW-1:0] step,
                           input int pts, input int dwell, input bit loop, input bit valid_on,
                           input int abort_at_in, input int start_mid, input bit abort_with_start,
                           output logic [PHW-1:0] last_phi);
    exp_t q[$];
    exp_t e;
    int   npts, ndw, laps, n_active, abort_at;
    bit   has_done;
    npts = (pts == 0) ? 1 : pts;
    ndw  = (dwell == 0) ? 1 : dwell;
    e = '{phi: inc, pt: '0, strobe: 1'b0, clken: 1'b1, rstn: 1'b0, busy: 1'b1, done: 1'b0,
          err: 1'b0};
    repeat (RST_CYCLES) q.push_back(e);
    e.rstn = 1'b1;
    if (!valid_on) begin
      repeat (VALID_TMO) q.push_back(e);
      e.clken = 1'b0; e.done = 1'b1; e.err = 1'b1;
      q.push_back(e);
      has_done = 1'b1;
    end else begin
      repeat (VLAT + 1) q.push_back(e);
      laps = loop ? 3 : 1;
      for (int l = 0; l < laps; l++) begin
        for (int p = 0; p < npts; p++) begin
          for (int c = 0; c < ndw; c++) begin
            e.phi    = inc + PHW'(p) * step;
            e.pt     = CW'(p);
            e.strobe = (c == 0) && (l > 0 || p > 0);
            q.push_back(e);
          end
        end
      end
      has_done = !loop;
      if (has_done) begin
        e.strobe = 1'b0; e.clken = 1'b0; e.done = 1'b1;
        q.push_back(e);
      end
    end
    n_active = q.size() - (has_done ? 1 : 0);
    abort_at = abort_at_in;
    if (abort_at >= n_active || (abort_at < 0 && !has_done)) abort_at = n_active - 1;
    if (abort_at >= 0) begin
      while (q.size() > abort_at + 1) void'(q.pop_back());
      e = q[abort_at];
      e.strobe = 1'b0; e.clken = 1'b0; e.rstn = 1'b1; e.done = 1'b1; e.err = 1'b0;
      q.push_back(e);
    end
    e = q[q.size() - 1];
    e.done = 1'b0; e.busy = 1'b0;
    q.push_back(e);
    last_phi = e.phi;

    @(negedge clk);
    stub_en       = valid_on;
    cfg_start_inc = inc;
    cfg_step_inc  = step;
    cfg_num_pts   = CW'(pts);
    cfg_dwell     = CW'(dwell);
    cfg_loop      = loop;
    start         = 1'b1;
    abort         = abort_with_start;
    @(negedge clk);
    start         = 1'b0;
    abort         = 1'b0;
    cfg_start_inc = $urandom;
    cfg_step_inc  = $urandom;
    cfg_num_pts   = CW'($urandom);
    cfg_dwell     = CW'($urandom);
    cfg_loop      = ~loop;
    for (int i = 0; i < q.size(); i++) begin
      cmp_cycle(tag, i, q[i]);
      if (i < q.size() - 1) begin
        abort = (i == abort_at);
        start = (i == start_mid);
        @(negedge clk);
      end
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    logic [PHW-1:0] lp;
    int pts, dw, ab, sm;
    bit lo, vo;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_loop = 1'b0; stub_en = 1'b1;
    cfg_start_inc = '0; cfg_step_inc = '0; cfg_num_pts = '0; cfg_dwell = '0;
    #1 check_reset("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle.rstn", nco_reset_n, 1);
    check("idle.busy", busy, 0);
    check("idle.clken", nco_clken, 0);

    run_sweep("t1", 32'h0333_3333, 32'h0010_0000, 4, 3, 1'b0, 1'b1, -1, -1, 1'b0, lp);
    check("t1.last", lp, 32'h0363_3333);
    check("t1.phi_end", phi_inc, 32'h0363_3333);

    run_sweep("t2a", 32'hFFF0_0000, 32'h0020_0000, 2, 2, 1'b0, 1'b1, -1, -1, 1'b0, lp);
    check("t2a.wrap", lp, 32'h0010_0000);
    run_sweep("t2b", 32'h0000_0000, 32'hFFF0_0000, 2, 1, 1'b0, 1'b1, -1, -1, 1'b0, lp);
    check("t2b.neg", lp, 32'hFFF0_0000);

    run_sweep("t3", 32'h1000_0000, 32'h0100_0000, 2, 2, 1'b1, 1'b1, 17, -1, 1'b0, lp);

    run_sweep("t4", 32'h0000_1234, 32'h0000_0001, 3, 2, 1'b0, 1'b0, -1, -1, 1'b0, lp);
    check("t4.err_sticky", err_tmo, 1);
    run_sweep("t4clr", 32'h0000_5678, 32'h0000_0002, 1, 2, 1'b0, 1'b1, -1, -1, 1'b0, lp);

    run_sweep("t5", 32'h2222_2222, 32'h1111_1111, 0, 0, 1'b0, 1'b1, -1, 3, 1'b1, lp);
    check("t5.last", lp, 32'h2222_2222);

    // Asynchronous reset mid-dwell.
    @(negedge clk);
    stub_en = 1'b1; cfg_start_inc = 32'h0ABC_0000; cfg_step_inc = 32'h0000_1000;
    cfg_num_pts = 16'd4; cfg_dwell = 16'd3; cfg_loop = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (RST_CYCLES + VLAT + 1 + 3) @(negedge clk);
    check("t6.pre_busy", busy, 1);
    check("t6.pre_pt", pt_idx, 1);
    #2 rst = 1'b1;
    #1 check_reset("t6.async");
    @(negedge clk);
    check_reset("t6.hold");
    rst = 1'b0;
    @(negedge clk);
    check("t6.rel_rstn", nco_reset_n, 1);
    check("t6.rel_done", done, 0);
    run_sweep("t6post", 32'h0000_0100, 32'h0000_0100, 3, 2, 1'b0, 1'b1, -1, -1, 1'b0, lp);
    check("t6post.last", lp, 32'h0000_0300);

    for (int k = 0; k < 30; k++) begin
      pts = $urandom_range(0, 4);
      dw  = $urandom_range(0, 3);
      lo  = ($urandom_range(0, 3) == 0);
      vo  = ($urandom_range(0, 7) != 0);
      ab  = (lo || $urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : -1;
      sm  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 12) : -1;
      run_sweep($sformatf("r%0d", k), $urandom, $urandom, pts, dw, lo, vo, ab, sm,
                ($urandom_range(0, 3) == 0), lp);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
